// File: rtl/flash_read_arbiter.sv
// -----------------------------------------------------------------------------
// flash_read_arbiter
//
// Shares one 16-bit flash read controller between the instruction-fetch bus
// (ibus) and the data bus (dbus). Each bus issues 32-bit word reads. A granted
// read is split into two halfword strobes (low address first, then high), the
// halfwords are assembled little-endian and the word is returned with a
// one-cycle ack. Ties between the buses are broken round-robin.
//
// Parameters
//   FC_LAT      cycles from the fc_read cycle to the cycle fc_rdata is valid (>= 2)
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   i_req_i, i_addr_i   ibus word read request (level) and byte address
//   i_ack_o, i_rdata_o  ibus one-cycle ack and read word
//   d_req_i, d_addr_i   dbus word read request (level) and byte address
//   d_ack_o, d_rdata_o  dbus one-cycle ack and read word
//   fc_read_o           one-cycle read strobe to the flash controller
//   fc_addr_o           flash byte address (bit 0 always 0), held between strobes
//   fc_rdata_i          halfword returned by the flash controller
//   busy_o              high whenever a transaction is in progress
// -----------------------------------------------------------------------------
module flash_read_arbiter #(
    parameter int FC_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_i,
    input  logic [31:0] i_addr_i,
    output logic        i_ack_o,
    output logic [31:0] i_rdata_o,
    input  logic        d_req_i,
    input  logic [31:0] d_addr_i,
    output logic        d_ack_o,
    output logic [31:0] d_rdata_o,
    output logic        fc_read_o,
    output logic [22:0] fc_addr_o,
    input  logic [15:0] fc_rdata_i,
    output logic        busy_o
);

    localparam int CW = $clog2(FC_LAT + 1);

    typedef enum logic [2:0] {
        IDLE,
        LO_WAIT,
        HI_ISSUE,
        HI_WAIT,
        DONE
    } state_e;

    typedef enum logic {
        GNT_IBUS,
        GNT_DBUS
    } grant_e;

    state_e          state_q, state_d;
    grant_e          last_q, last_d;
    grant_e          grant_q, grant_d;
    logic [20:0]     addr_q, addr_d;     // word address bits [22:2] of the granted read
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [15:0]     lo_q, lo_d;
    logic            fc_read_q, fc_read_d;
    logic [22:0]     fc_addr_q, fc_addr_d;
    logic            i_ack_q, i_ack_d;
    logic            d_ack_q, d_ack_d;
    logic [31:0]     i_rdata_q, i_rdata_d;
    logic [31:0]     d_rdata_q, d_rdata_d;

    // Arbitration decision, only acted on in IDLE.
    grant_e          pick;
    logic [20:0]     pick_addr;

    // Byte-lane and upper address bits never reach flash.
    logic            unused_addr_bits;
    assign unused_addr_bits = ^{i_addr_i[31:23], i_addr_i[1:0], d_addr_i[31:23], d_addr_i[1:0]};

    always_comb begin
        pick = d_req_i ? GNT_DBUS : GNT_IBUS;
        if (i_req_i && d_req_i) begin
            // Tie: the bus that did not win last time goes first.
            pick = (last_q == GNT_IBUS) ? GNT_DBUS : GNT_IBUS;
        end
        pick_addr = (pick == GNT_DBUS) ? d_addr_i[22:2] : i_addr_i[22:2];
    end

    always_comb begin
        // NOTE: every next-state signal gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        last_d    = last_q;
        grant_d   = grant_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        lo_d      = lo_q;
        fc_read_d = 1'b0;       // strobe and acks are single-cycle pulses
        fc_addr_d = fc_addr_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (i_req_i || d_req_i) begin
                    grant_d   = pick;
                    last_d    = pick;
                    addr_d    = pick_addr;
                    fc_read_d = 1'b1;
                    fc_addr_d = {pick_addr, 2'b00};
                    cnt_d     = CW'(FC_LAT);
                    state_d   = LO_WAIT;
                end
            end

            LO_WAIT: begin
                // The low halfword is valid FC_LAT cycles after the strobe; the
                // high strobe is registered here so it appears in HI_ISSUE.
                if (cnt_q == '0) begin
                    lo_d      = fc_rdata_i;
                    fc_read_d = 1'b1;
                    fc_addr_d = {addr_q, 2'b10};
                    state_d   = HI_ISSUE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            HI_ISSUE: begin
                // HI_WAIT lasts FC_LAT cycles, ending on the fc_rdata cycle.
                cnt_d   = CW'(FC_LAT - 1);
                state_d = HI_WAIT;
            end

            HI_WAIT: begin
                if (cnt_q == '0) begin
                    if (grant_q == GNT_DBUS) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = {fc_rdata_i, lo_q};
                    end else begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = {fc_rdata_i, lo_q};
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= GNT_IBUS;
            grant_q   <= GNT_IBUS;
            addr_q    <= '0;
            cnt_q     <= '0;
            lo_q      <= '0;
            fc_read_q <= 1'b0;
            fc_addr_q <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            lo_q      <= lo_d;
            fc_read_q <= fc_read_d;
            fc_addr_q <= fc_addr_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign fc_read_o = fc_read_q;
    assign fc_addr_o = fc_addr_q;
    assign i_ack_o   = i_ack_q;
    assign d_ack_o   = d_ack_q;
    assign i_rdata_o = i_rdata_q;
    assign d_rdata_o = d_rdata_q;
    assign busy_o    = (state_q != IDLE);

endmodule
